// File: rtl/neuron_value_fifo_pkg.sv
// Shared neuron datapath types and default sizing for the layer-to-layer value FIFO.
package neuron_pkg;

  localparam int NEURON_DATA_W     = 21;
  localparam int NEURON_FIFO_DEPTH = 4;

  typedef logic signed [NEURON_DATA_W-1:0] neuron_val_t;

endpackage

// File: rtl/neuron_value_fifo.sv
// Show-ahead register-based FIFO releasing signed neuron values to the next layer.
// Optional sticky overflow flag output `ovf` when NEURON_FIFO_OVF_FLAG_EN is defined.
module neuron_value_fifo
  import neuron_pkg::*;
#(
  parameter  int DATA_W = NEURON_DATA_W,
  parameter  int DEPTH  = NEURON_FIFO_DEPTH,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic signed [DATA_W-1:0] wr_data,
  output logic                     full,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic signed [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]         count
`ifdef NEURON_FIFO_OVF_FLAG_EN
  ,
  output logic                     ovf
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic signed [DATA_W-1:0] mem_q [DEPTH];
  logic signed [DATA_W-1:0] mem_d [DEPTH];

  logic push, pop;

  // Status comes from the registered occupancy so it is glitch-free and
  // unambiguous when the pointers are equal.
  assign full     = (count_q == CNT_W'(DEPTH));
  assign rd_valid = (count_q != '0);
  assign count    = count_q;
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;

  assign pop  = rd_valid && rd_ready;
  assign push = wr_en && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop)
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; rd_data is masked while empty instead.
  always_ff @(posedge clk) begin
    if (!rst)
      mem_q <= mem_d;
  end

`ifdef NEURON_FIFO_OVF_FLAG_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (wr_en && full && !pop)
      ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_neuron_value_fifo.sv
// Self-checking bench for neuron_value_fifo: directed scenarios plus a randomized run against a queue model.
module tb_neuron_value_fifo;

  localparam int DATA_W = 21;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     wr_en = 1'b0;
  logic signed [DATA_W-1:0] wr_data = '0;
  logic                     rd_ready = 1'b0;
  logic                     full, rd_valid;
  logic signed [DATA_W-1:0] rd_data;
  logic [CNT_W-1:0]         count;
`ifdef NEURON_FIFO_OVF_FLAG_EN
  logic                     ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: FIFO contents as a plain queue, plus sticky overflow.
  logic signed [DATA_W-1:0] mq [$];
  logic                     ovf_exp = 1'b0;

  neuron_value_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .count(count)
`ifdef NEURON_FIFO_OVF_FLAG_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, clock it, and advance the model.
  task automatic step(input logic r, input logic we, input logic signed [DATA_W-1:0] wd,
                      input logic rr);
    bit do_pop, do_push;
    rst = r; wr_en = we; wr_data = wd; rd_ready = rr;
    do_pop  = (mq.size() != 0) && rr;
    do_push = we && ((mq.size() < DEPTH) || do_pop);
    @(posedge clk);
    if (r) begin
      mq.delete();
      ovf_exp = 1'b0;
    end else begin
      if (we && !do_push) ovf_exp = 1'b1;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(wd);
    end
    #1;
    rst = 1'b0; wr_en = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    n_checks++; if (count !== 0)    begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (rd_valid !== 0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", rd_valid); end
    n_checks++; if (full !== 0)     begin n_fail++; $display("FAIL reset_full: got %0b expected 0", full); end
    n_checks++; if (rd_data !== 0)  begin n_fail++; $display("FAIL reset_data: got %0d expected 0", rd_data); end
`ifdef NEURON_FIFO_OVF_FLAG_EN
    n_checks++; if (ovf !== 0)      begin n_fail++; $display("FAIL reset_ovf: got %0b expected 0", ovf); end
`endif
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1);
      n_checks++;
      if (count !== 0 || rd_valid !== 0 || rd_data !== 0) begin
        n_fail++; $display("FAIL idle_pop_empty: got count=%0d valid=%0b data=%0d expected 0/0/0", count, rd_valid, rd_data);
      end
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) step(0, 1, DATA_W'(i * 8), 0);
    n_checks++; if (count !== 4) begin n_fail++; $display("FAIL fill_count: got %0d expected 4", count); end
    n_checks++; if (full !== 1)  begin n_fail++; $display("FAIL fill_full: got %0b expected 1", full); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rd_valid !== 1 || rd_data !== DATA_W'(i * 8)) begin
        n_fail++; $display("FAIL drain_data[%0d]: got valid=%0b data=%0d expected 1/%0d", i, rd_valid, rd_data, i * 8);
      end
      step(0, 0, 0, 1);
    end
    n_checks++; if (rd_valid !== 0) begin n_fail++; $display("FAIL drain_empty: got valid=%0b expected 0", rd_valid); end
  endtask

  task automatic test_overflow();
    logic signed [DATA_W-1:0] v [4] = '{10, -10, 20, -20};
    for (int i = 0; i < 4; i++) step(0, 1, v[i], 0);
    step(0, 1, 99, 0);
    n_checks++; if (count !== 4) begin n_fail++; $display("FAIL ovf_count: got %0d expected 4", count); end
`ifdef NEURON_FIFO_OVF_FLAG_EN
    n_checks++; if (ovf !== 1)   begin n_fail++; $display("FAIL ovf_flag_set: got %0b expected 1", ovf); end
`endif
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rd_data !== v[i]) begin n_fail++; $display("FAIL ovf_drain[%0d]: got %0d expected %0d", i, rd_data, v[i]); end
`ifdef NEURON_FIFO_OVF_FLAG_EN
      n_checks++; if (ovf !== 1) begin n_fail++; $display("FAIL ovf_sticky[%0d]: got %0b expected 1", i, ovf); end
`endif
      step(0, 0, 0, 1);
    end
    n_checks++; if (rd_valid !== 0) begin n_fail++; $display("FAIL ovf_drop_not_stored: got valid=%0b data=%0d expected empty", rd_valid, rd_data); end
  endtask

  task automatic test_full_push_pop();
    logic signed [DATA_W-1:0] exp [4] = '{2, 3, 4, 5};
    for (int i = 1; i <= 4; i++) step(0, 1, DATA_W'(i), 0);
    n_checks++; if (rd_data !== 1) begin n_fail++; $display("FAIL fpp_head: got %0d expected 1", rd_data); end
    step(0, 1, 5, 1);
    n_checks++; if (count !== 4 || full !== 1) begin n_fail++; $display("FAIL fpp_count: got count=%0d full=%0b expected 4/1", count, full); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rd_data !== exp[i]) begin n_fail++; $display("FAIL fpp_drain[%0d]: got %0d expected %0d", i, rd_data, exp[i]); end
      step(0, 0, 0, 1);
    end
  endtask

  task automatic test_signed_wrap();
    logic signed [DATA_W-1:0] v;
    for (int i = 0; i < 12; i++) begin
      v = (i % 2 == 0) ? -21'sd1048576 : 21'sd1048575;
      step(0, 1, v, 1);
      n_checks++;
      if (count !== 1 || rd_data !== v) begin
        n_fail++; $display("FAIL wrap[%0d]: got count=%0d data=%0d expected 1/%0d", i, count, rd_data, v);
      end
    end
    step(0, 0, 0, 1);
    n_checks++; if (count !== 0) begin n_fail++; $display("FAIL wrap_final: got %0d expected 0", count); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(0, 1, DATA_W'(100 + i), 0);
    n_checks++; if (count !== 3) begin n_fail++; $display("FAIL rmid_pre: got %0d expected 3", count); end
    step(1, 1, 77, 1);
    n_checks++;
    if (count !== 0 || rd_valid !== 0 || rd_data !== 0) begin
      n_fail++; $display("FAIL rmid_post: got count=%0d valid=%0b data=%0d expected 0/0/0", count, rd_valid, rd_data);
    end
    step(0, 0, 0, 0);
    n_checks++; if (count !== 0) begin n_fail++; $display("FAIL rmid_not_stored: got %0d expected 0", count); end
  endtask

  task automatic test_random();
    logic signed [DATA_W-1:0] exp_data;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(99) < 60),
           DATA_W'($urandom), ($urandom_range(99) < 45));
      exp_data = (mq.size() != 0) ? mq[0] : '0;
      n_checks++;
      if (count !== CNT_W'(mq.size()) || rd_valid !== (mq.size() != 0) ||
          full !== (mq.size() == DEPTH) || rd_data !== exp_data) begin
        n_fail++;
        $display("FAIL random[%0d]: got count=%0d valid=%0b full=%0b data=%0d expected %0d/%0b/%0b/%0d",
                 i, count, rd_valid, full, rd_data, mq.size(), mq.size() != 0, mq.size() == DEPTH, exp_data);
      end
`ifdef NEURON_FIFO_OVF_FLAG_EN
      n_checks++;
      if (ovf !== ovf_exp) begin n_fail++; $display("FAIL random_ovf[%0d]: got %0b expected %0b", i, ovf, ovf_exp); end
`endif
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_fill_drain();
    test_overflow();
    step(1, 0, 0, 0);
    test_full_push_pop();
    test_signed_wrap();
    test_reset_mid();
    step(1, 0, 0, 0);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/neuron_value_fifo.md
Name: neuron_value_fifo

Overview:
- Read-side companion to the single-register `buffer` stage: a small show-ahead FIFO that holds signed neuron values produced upstream.
- Releases values to a downstream consumer (accumulator / activation stage) with a valid/ready handshake.
- Absorbs rate mismatch between producer and consumer and decouples their timing.
- Sits between the per-neuron `buffer` register and the next-layer input logic.

Parameters:
- DATA_W, 21, width of each signed value (two's complement).
- DEPTH, 4, number of entries; must be a power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter (derived; do not override).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  producer pushes wr_data this cycle.
- wr_data  input  DATA_W  signed value to push.
- full  output  1  high when count == DEPTH.
- rd_valid  output  1  rd_data holds the oldest entry (high when count != 0).
- rd_ready  input  1  consumer accepts rd_data this cycle.
- rd_data  output  DATA_W  signed oldest entry (show-ahead).
- count  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst sampled high at an edge): wr_ptr=0, rd_ptr=0, count=0, so full=0 and rd_valid=0. rd_data=0 while empty (forced, not stale memory). Storage contents are not cleared.
- Reset overrides a push or pop in the same cycle. Mid-operation reset discards all entries.
- push = wr_en && (!full || pop). pop = rd_valid && rd_ready.
- Push: mem[wr_ptr] <= wr_data; wr_ptr increments mod DEPTH and wraps naturally.
- Pop: rd_ptr increments mod DEPTH.
- count: +1 on push only; -1 on pop only; unchanged on both or neither.
- Latency: a value pushed at edge N is visible on rd_data, with rd_valid=1, immediately after edge N (one cycle). There is no fall-through from wr_data to rd_data in the same cycle.
- rd_data = mem[rd_ptr] when count != 0, else 0. Driven from registered state only, with no combinational path from wr_data.
- Full, with simultaneous push and pop: both happen; count stays at DEPTH.
- Full, push without pop: the write is dropped and no state changes.
- Empty, rd_ready high: no pop occurs and rd_ptr is unchanged.
- Empty, push (rd_ready is irrelevant): push only. Valid appears next cycle.
- Values are stored bit-exact; sign is preserved. No arithmetic is applied to the data.
- full and rd_valid are derived from count (registered), never from pointer comparison alone.

Optional Feature:
- Macro: NEURON_FIFO_OVF_FLAG_EN.
- When defined, adds output port `ovf` (1 bit), a sticky flag:
  - set on the edge after any dropped write (wr_en && full && !pop);
  - cleared only by rst;
  - reset value 0.
- When undefined, the port does not exist and dropped writes are silent. All other behaviour is identical.

Decomposition:
- Package neuron_pkg holds:
  - localparam NEURON_DATA_W = 21;
  - typedef logic signed [NEURON_DATA_W-1:0] neuron_val_t;
  - the default FIFO depth constant NEURON_FIFO_DEPTH = 4.
- No sub-module is needed. Pointer/count logic and storage live in one module (about 150 lines). The storage array is inferred as registers, not RAM.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then release -> count=0, rd_valid=0, full=0, rd_data=0. Hold rd_ready=1 for 5 cycles -> nothing changes.
- Push 0,8,16,24 (one per cycle, rd_ready=0) -> after 4th push count=4, full=1. Then rd_ready=1 -> rd_data sequence 0,8,16,24 on consecutive cycles, then rd_valid=0.
- Overflow: fill with 10,-10,20,-20, then push 99 with rd_ready=0 -> 99 dropped, count stays 4, drain yields 10,-10,20,-20. With NEURON_FIFO_OVF_FLAG_EN, ovf=1 after the drop and stays 1 through the drain.
- Full plus simultaneous push/pop: full with 1,2,3,4; push 5 with rd_ready=1 -> 1 popped, count=4, subsequent drain yields 2,3,4,5.
- Signed extremes and wrap: push -1048576 and 1048575 alternately for 12 cycles with rd_ready=1 -> rd_data matches bit-exact and in order across multiple pointer wraps; count oscillates 0/1 only.
- Reset mid-operation: with count=3, assert rst for 1 cycle while wr_en=1 and rd_ready=1 -> next cycle count=0, rd_valid=0, and the pushed value is not stored.
